// File: rtl/signal_extension.sv
// signal_extension: registered immediate-operand extender for the BIP datapath.
// Widens the IN_W-bit operand/address field of an instruction to OUT_W bits,
// sign-extending by default or zero-extending when Zext is set. The result is
// registered so it sits between instruction decode and the ALU operand mux.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   En      in   1      load enable; Addr/Zext are sampled this cycle
//   Zext    in   1      0 = sign-extend, 1 = zero-extend
//   Addr    in   IN_W   operand field from the instruction word
//   Salida  out  OUT_W  registered extended operand
//   Valid   out  1      Salida was updated on the last clock edge
module signal_extension #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             Zext,
    input  logic [IN_W-1:0]  Addr,
    output logic [OUT_W-1:0] Salida,
    output logic             Valid
);

    // Reject parameter sets that leave no sign bit or nothing to extend.
    generate
        if ((IN_W < 2) || (OUT_W <= IN_W)) begin : g_bad_params
            $error("signal_extension: need IN_W >= 2 and OUT_W > IN_W");
        end
    endgenerate

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [EXT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_salida;
    logic             r_valid;

    // Upper bits replicate the operand MSB in sign mode and are cleared in zero mode.
    always_comb begin
        w_upper = '0;
        if (!Zext) begin
            w_upper = {EXT_W{Addr[IN_W-1]}};
        end
        w_ext = {w_upper, Addr};
    end

    // Output registers; Salida holds while En is low, Valid flags a fresh load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_salida <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= En;
            if (En) begin
                r_salida <= w_ext;
            end
        end
    end

    assign Salida = r_salida;
    assign Valid  = r_valid;

endmodule

// File: tb/tb_signal_extension.sv
// Scoreboard bench for signal_extension: the driver pushes the hand-computed
// extended value for every enabled edge; a monitor pops and compares whenever
// Valid is seen. Hold and reset behaviour is checked directly by the driver.
module tb_signal_extension;

    localparam int unsigned IN_W  = 11;
    localparam int unsigned OUT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             En;
    logic             Zext;
    logic [IN_W-1:0]  Addr;
    logic [OUT_W-1:0] Salida;
    logic             Valid;

    int n_cmp;
    int n_bad;
    logic [OUT_W-1:0] exp_q[$];

    signal_extension #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .Zext   (Zext),
        .Addr   (Addr),
        .Salida (Salida),
        .Valid  (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, got, want);
        end
    endtask

    // Drive inputs on the falling edge, then record the expectation for the rising edge.
    task automatic step(input logic en, input logic zext, input logic [IN_W-1:0] addr,
                        input logic [OUT_W-1:0] want);
        @(negedge clk);
        En   = en;
        Zext = zext;
        Addr = addr;
        @(posedge clk);
        if (en && rst_n) exp_q.push_back(want);
    endtask

    // Monitor: compare each presented output against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (Valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got Salida 0x%04h with empty scoreboard", Salida);
                end else begin
                    check("scoreboard", Salida, exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        En    = 1'b1;
        Zext  = 1'b0;
        Addr  = 11'h7FF;

        // Reset held with a live load request: outputs must stay cleared.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("reset_salida", Salida, 16'h0000);
            check("reset_valid", {15'd0, Valid}, 16'h0000);
        end
        @(negedge clk);
        En    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);

        // Positive sign extension.
        step(1'b1, 1'b0, 11'h222, 16'h0222);
        step(1'b1, 1'b0, 11'h1E2, 16'h01E2);
        // Negative sign extension, back to back.
        step(1'b1, 1'b0, 11'h422, 16'hFC22);
        step(1'b1, 1'b0, 11'h7FF, 16'hFFFF);
        step(1'b1, 1'b0, 11'h400, 16'hFC00);
        // Zero extension.
        step(1'b1, 1'b1, 11'h7FF, 16'h07FF);
        step(1'b1, 1'b1, 11'h400, 16'h0400);
        step(1'b1, 1'b1, 11'h000, 16'h0000);

        // Hold: load 0xFC22, then inputs wiggle with En low.
        step(1'b1, 1'b0, 11'h422, 16'hFC22);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0], 11'h001, 16'h0000);
            #2;
            check("hold_salida", Salida, 16'hFC22);
            check("hold_valid", {15'd0, Valid}, 16'h0000);
        end

        // Stream alternating operands, then assert reset between edges.
        for (int i = 0; i < 4; i++) begin
            if (i[0]) step(1'b1, 1'b0, 11'h001, 16'h0001);
            else      step(1'b1, 1'b0, 11'h7FF, 16'hFFFF);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_salida", Salida, 16'h0000);
        check("async_rst_valid", {15'd0, Valid}, 16'h0000);
        step(1'b1, 1'b0, 11'h7FF, 16'hFFFF);
        #2;
        check("rst_edge_salida", Salida, 16'h0000);
        check("rst_edge_valid", {15'd0, Valid}, 16'h0000);

        // Release with En low, then load 0x001.
        @(negedge clk);
        En    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        step(1'b1, 1'b0, 11'h001, 16'h0001);
        step(1'b0, 1'b0, 11'h000, 16'h0000);
        #2;
        check("post_rst_hold", Salida, 16'h0001);

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
